// File: rtl/otter_dcdr_stage_if.sv
// Handshake bundles around the OTTER decode stage: fetch->decode and decode->execute.
interface otter_fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_ir;
  logic [XLEN-1:0] in_pc;

  modport master (output in_valid, output in_ir, output in_pc, input in_ready);
  modport slave  (input in_valid, input in_ir, input in_pc, output in_ready);
endinterface

interface otter_dcdr_if #(
  parameter int unsigned XLEN = 32
);
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_ir;
  logic [XLEN-1:0] out_pc;
  logic [3:0]      ALU_FUN;
  logic [1:0]      ALU_srcA;
  logic [2:0]      ALU_srcB;
  logic [1:0]      rf_wr_sel;
  logic            rf_we;
  logic            mem_we;
  logic            mem_rden;
  logic [2:0]      pc_op;
  logic [2:0]      br_funct3;
  logic            md_valid;
  logic [2:0]      md_fun;
  logic            illegal;

  modport master (
    output out_valid, output out_ir, output out_pc,
    output ALU_FUN, output ALU_srcA, output ALU_srcB, output rf_wr_sel,
    output rf_we, output mem_we, output mem_rden, output pc_op,
    output br_funct3, output md_valid, output md_fun, output illegal,
    input  out_ready
  );
  modport slave (
    input  out_valid, input out_ir, input out_pc,
    input  ALU_FUN, input ALU_srcA, input ALU_srcB, input rf_wr_sel,
    input  rf_we, input mem_we, input mem_rden, input pc_op,
    input  br_funct3, input md_valid, input md_fun, input illegal,
    output out_ready
  );
endinterface

// File: rtl/otter_dcdr_stage.sv
// OTTER decode stage: combinational RV32I(+M) decode registered into a
// two-slot (main/skid) valid/ready buffer with a registered in_ready.
module otter_dcdr_stage #(
  parameter int unsigned XLEN  = 32,
  parameter bit          M_EXT = 1'b0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         flush,
  otter_fetch_if.slave fetch,
  otter_dcdr_if.master exec
);

  typedef enum logic [6:0] {
    OP_RTYPE  = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_MAIN,
    ST_FULL
  } state_t;

  typedef struct packed {
    logic [3:0] alu_fun;
    logic [1:0] alu_srca;
    logic [2:0] alu_srcb;
    logic [1:0] rf_wr_sel;
    logic       rf_we;
    logic       mem_we;
    logic       mem_rden;
    logic [2:0] pc_op;
    logic [2:0] br_funct3;
    logic       md_valid;
    logic [2:0] md_fun;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    ctl_t            ctl;
    logic [31:0]     ir;
    logic [XLEN-1:0] pc;
  } bundle_t;

  logic [2:0] funct3;
  logic [6:0] funct7;
  ctl_t       raw;
  ctl_t       dec;
  logic       ill;
  bundle_t    in_bundle;

  assign funct3 = fetch.in_ir[14:12];
  assign funct7 = fetch.in_ir[31:25];

  always_comb begin
    raw = '0;
    ill = 1'b0;
    case (fetch.in_ir[6:0])
      OP_RTYPE: begin
        raw.rf_we     = 1'b1;
        raw.rf_wr_sel = 2'b11;
        case (funct7)
          7'b0000000: raw.alu_fun = {1'b0, funct3};
          7'b0100000: begin
            if (funct3 == 3'b000)      raw.alu_fun = 4'b1000;
            else if (funct3 == 3'b101) raw.alu_fun = 4'b1101;
            else                       ill = 1'b1;
          end
          7'b0000001: begin
            if (M_EXT) begin
              raw.md_valid  = 1'b1;
              raw.md_fun    = funct3;
              raw.rf_wr_sel = 2'b00;
            end else begin
              ill = 1'b1;
            end
          end
          default: ill = 1'b1;
        endcase
      end
      OP_IALU: begin
        raw.alu_srcb  = 3'b001;
        raw.rf_we     = 1'b1;
        raw.rf_wr_sel = 2'b11;
        raw.alu_fun   = {1'b0, funct3};
        if (funct3 == 3'b001) begin
          ill = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          raw.alu_fun = {fetch.in_ir[30], 3'b101};
          ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end
      end
      OP_LOAD: begin
        raw.alu_srcb  = 3'b001;
        raw.mem_rden  = 1'b1;
        raw.rf_we     = 1'b1;
        raw.rf_wr_sel = 2'b10;
        ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        raw.alu_srcb = 3'b010;
        raw.mem_we   = 1'b1;
        ill = (funct3 >= 3'b011);
      end
      OP_BRANCH: begin
        raw.pc_op     = 3'b010;
        raw.br_funct3 = funct3;
        ill = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_LUI: begin
        raw.alu_srca  = 2'b01;
        raw.alu_fun   = 4'b1001;
        raw.rf_we     = 1'b1;
        raw.rf_wr_sel = 2'b11;
      end
      OP_AUIPC: begin
        raw.alu_srca  = 2'b01;
        raw.alu_srcb  = 3'b011;
        raw.rf_we     = 1'b1;
        raw.rf_wr_sel = 2'b11;
      end
      OP_JAL: begin
        raw.pc_op     = 3'b011;
        raw.rf_we     = 1'b1;
        raw.rf_wr_sel = 2'b01;
      end
      OP_JALR: begin
        raw.alu_srcb  = 3'b001;
        raw.pc_op     = 3'b001;
        raw.rf_we     = 1'b1;
        raw.rf_wr_sel = 2'b01;
        ill = (funct3 != 3'b000);
      end
      default: ill = 1'b1;
    endcase
  end

  // An undecodable word carries no control at all, only the illegal flag.
  always_comb begin
    dec = raw;
    if (ill) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign in_bundle = {dec, fetch.in_ir, fetch.in_pc};

  state_t  state;
  state_t  state_nxt;
  bundle_t main_q;
  bundle_t skid_q;
  logic    in_ready_q;
  logic    main_valid;
  logic    accept;
  logic    drain;
  logic    load_main_in;
  logic    load_main_skid;
  logic    load_skid;

  assign main_valid = (state != ST_EMPTY);
  assign accept     = fetch.in_valid & in_ready_q & ~flush;
  assign drain      = main_valid & exec.out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_nxt    = ST_MAIN;
        end
      end
      ST_MAIN: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = ST_FULL;
        end else if (drain) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          load_main_skid = 1'b1;
          state_nxt      = ST_MAIN;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush) state_nxt = ST_EMPTY;
  end

  // in_ready is a flop that tracks "skid will be empty" one edge ahead.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_bundle;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_bundle;
    end
  end

  assign fetch.in_ready = in_ready_q;

  assign exec.out_valid = main_valid;
  assign exec.out_ir    = main_q.ir;
  assign exec.out_pc    = main_q.pc;
  assign exec.ALU_FUN   = main_q.ctl.alu_fun;
  assign exec.ALU_srcA  = main_q.ctl.alu_srca;
  assign exec.ALU_srcB  = main_q.ctl.alu_srcb;
  assign exec.rf_wr_sel = main_q.ctl.rf_wr_sel;
  assign exec.rf_we     = main_q.ctl.rf_we;
  assign exec.mem_we    = main_q.ctl.mem_we;
  assign exec.mem_rden  = main_q.ctl.mem_rden;
  assign exec.pc_op     = main_q.ctl.pc_op;
  assign exec.br_funct3 = main_q.ctl.br_funct3;
  assign exec.md_valid  = main_q.ctl.md_valid;
  assign exec.md_fun    = main_q.ctl.md_fun;
  assign exec.illegal   = main_q.ctl.illegal;

endmodule

// File: tb/tb_otter_dcdr_stage.sv
// Bench for otter_dcdr_stage: two instances (M_EXT=0/1) driven identically and
// compared each cycle against a queue-based occupancy model and a rule-level decoder.
module tb_otter_dcdr_stage;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] srca;
    logic [2:0] srcb;
    logic [1:0] wsel;
    logic       rf_we;
    logic       mem_we;
    logic       mem_rden;
    logic [2:0] pc_op;
    logic [2:0] br;
    logic       md;
    logic [2:0] mdf;
    logic       illegal;
  } exp_t;

  typedef struct {
    logic [31:0]     ir;
    logic [XLEN-1:0] pc;
  } instr_t;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            tb_flush = 1'b0;
  logic            tb_valid = 1'b0;
  logic [31:0]     tb_ir = '0;
  logic [XLEN-1:0] tb_pc = '0;
  logic            tb_ordy = 1'b0;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  instr_t          src[$];
  instr_t          mq[$];
  bit              m_rdy  = 1'b1;
  bit              in_rst = 1'b1;
  logic [XLEN-1:0] pc_ctr = 32'h0000_1000;

  otter_fetch_if #(.XLEN(XLEN)) fa ();
  otter_dcdr_if  #(.XLEN(XLEN)) ea ();
  otter_fetch_if #(.XLEN(XLEN)) fb ();
  otter_dcdr_if  #(.XLEN(XLEN)) eb ();

  assign fa.in_valid  = tb_valid;
  assign fa.in_ir     = tb_ir;
  assign fa.in_pc     = tb_pc;
  assign ea.out_ready = tb_ordy;
  assign fb.in_valid  = tb_valid;
  assign fb.in_ir     = tb_ir;
  assign fb.in_pc     = tb_pc;
  assign eb.out_ready = tb_ordy;

  otter_dcdr_stage #(.XLEN(XLEN), .M_EXT(1'b0)) u_dut_rv32i (
    .CLK(CLK), .RST_N(RST_N), .flush(tb_flush), .fetch(fa), .exec(ea)
  );
  otter_dcdr_stage #(.XLEN(XLEN), .M_EXT(1'b1)) u_dut_rv32im (
    .CLK(CLK), .RST_N(RST_N), .flush(tb_flush), .fetch(fb), .exec(eb)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Decode rules written straight from the instruction-set table.
  function automatic exp_t ref_decode(input logic [31:0] w, input bit mext);
    exp_t e;
    bit ok;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    e = '0; ok = 1'b1;
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    case (opc)
      7'h33: begin
        e.rf_we = 1; e.wsel = 2'd3;
        if (f7 == 7'h00) e.alu = {1'b0, f3};
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.alu = {1'b1, f3};
        else if (f7 == 7'h01 && mext) begin e.md = 1; e.mdf = f3; e.wsel = 2'd0; end
        else ok = 0;
      end
      7'h13: begin
        e.srcb = 3'd1; e.rf_we = 1; e.wsel = 2'd3;
        e.alu = {(f3 == 3'd5) ? w[30] : 1'b0, f3};
        if (f3 == 3'd1 && f7 != 7'h00) ok = 0;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ok = 0;
      end
      7'h03: begin
        e.srcb = 3'd1; e.mem_rden = 1; e.rf_we = 1; e.wsel = 2'd2;
        ok = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      7'h23: begin e.srcb = 3'd2; e.mem_we = 1; ok = (f3 < 3'd3); end
      7'h63: begin e.pc_op = 3'd2; e.br = f3; ok = (f3 != 3'd2 && f3 != 3'd3); end
      7'h37: begin e.srca = 2'd1; e.alu = 4'd9; e.rf_we = 1; e.wsel = 2'd3; end
      7'h17: begin e.srca = 2'd1; e.srcb = 3'd3; e.rf_we = 1; e.wsel = 2'd3; end
      7'h6f: begin e.pc_op = 3'd3; e.rf_we = 1; e.wsel = 2'd1; end
      7'h67: begin e.srcb = 3'd1; e.pc_op = 3'd1; e.rf_we = 1; e.wsel = 2'd1; ok = (f3 == 3'd0); end
      default: ok = 0;
    endcase
    if (!ok) begin e = '0; e.illegal = 1; end
    return e;
  endfunction

  function automatic exp_t mk(input logic [3:0] a, input logic [1:0] sa, input logic [2:0] sb,
                              input logic [1:0] ws, input logic we, input logic mw, input logic mr,
                              input logic [2:0] po, input logic [2:0] bf, input logic mv,
                              input logic [2:0] mf, input logic il);
    return {a, sa, sb, ws, we, mw, mr, po, bf, mv, mf, il};
  endfunction

  task automatic check_side(input string s, input bit mext, input logic rdy, input logic vld,
                            input logic [31:0] ir, input logic [XLEN-1:0] pc, input exp_t g);
    exp_t e;
    if (in_rst) begin
      check({s, ".rst.in_ready"}, rdy, 1);
      check({s, ".rst.out_valid"}, vld, 0);
      check({s, ".rst.out_ir"}, ir, 0);
      check({s, ".rst.out_pc"}, pc, 0);
      check({s, ".rst.ctl"}, g, 0);
    end else begin
      check({s, ".in_ready"}, rdy, m_rdy);
      check({s, ".out_valid"}, vld, mq.size() != 0);
      if (mq.size() != 0) begin
        e = ref_decode(mq[0].ir, mext);
        check({s, ".out_ir"}, ir, mq[0].ir);
        check({s, ".out_pc"}, pc, mq[0].pc);
        check({s, ".ALU_FUN"}, g.alu, e.alu);
        check({s, ".ALU_srcA"}, g.srca, e.srca);
        check({s, ".ALU_srcB"}, g.srcb, e.srcb);
        check({s, ".rf_wr_sel"}, g.wsel, e.wsel);
        check({s, ".rf_we"}, g.rf_we, e.rf_we);
        check({s, ".mem_we"}, g.mem_we, e.mem_we);
        check({s, ".mem_rden"}, g.mem_rden, e.mem_rden);
        check({s, ".pc_op"}, g.pc_op, e.pc_op);
        if (e.pc_op == 3'd2 || e.illegal) check({s, ".br_funct3"}, g.br, e.br);
        check({s, ".md_valid"}, g.md, e.md);
        check({s, ".md_fun"}, g.mdf, e.mdf);
        check({s, ".illegal"}, g.illegal, e.illegal);
      end
    end
  endtask

  task automatic check_all();
    check_side("rv32i", 1'b0, fa.in_ready, ea.out_valid, ea.out_ir, ea.out_pc,
      mk(ea.ALU_FUN, ea.ALU_srcA, ea.ALU_srcB, ea.rf_wr_sel, ea.rf_we, ea.mem_we, ea.mem_rden,
         ea.pc_op, ea.br_funct3, ea.md_valid, ea.md_fun, ea.illegal));
    check_side("rv32im", 1'b1, fb.in_ready, eb.out_valid, eb.out_ir, eb.out_pc,
      mk(eb.ALU_FUN, eb.ALU_srcA, eb.ALU_srcB, eb.rf_wr_sel, eb.rf_we, eb.mem_we, eb.mem_rden,
         eb.pc_op, eb.br_funct3, eb.md_valid, eb.md_fun, eb.illegal));
  endtask

  task automatic push(input logic [31:0] w);
    instr_t i;
    i.ir = w; i.pc = pc_ctr;
    pc_ctr += 4;
    src.push_back(i);
  endtask

  // Called at a falling edge: check, drive the next inputs, advance the model to the coming edge.
  task automatic cycle_body(input bit ordy, input bit vgate, input bit fl);
    bit acc, drn;
    check_all();
    tb_valid = vgate && (src.size() != 0);
    tb_ir    = (src.size() != 0) ? src[0].ir : $urandom;
    tb_pc    = (src.size() != 0) ? src[0].pc : $urandom;
    tb_ordy  = ordy;
    tb_flush = fl;
    acc = tb_valid && m_rdy && !fl;
    drn = (mq.size() != 0) && ordy;
    if (fl) begin
      mq.delete();
      if (tb_valid) void'(src.pop_front());
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(src.pop_front());
    end
    m_rdy = (mq.size() < 2);
  endtask

  task automatic tick(input bit ordy, input bit vgate, input bit fl);
    @(negedge CLK);
    cycle_body(ordy, vgate, fl);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 RST_N = 1'b0;
    in_rst = 1'b1;
    mq.delete();
    m_rdy = 1'b1;
    #1 check_all();
    repeat (2) begin
      @(negedge CLK);
      check_all();
    end
    @(negedge CLK);
    RST_N  = 1'b1;
    in_rst = 1'b0;
    cycle_body(1'b1, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] w;
    int unsigned k;
    w = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0, 1: w[6:0] = 7'h33;
      2, 3: w[6:0] = 7'h13;
      4:    w[6:0] = 7'h03;
      5:    w[6:0] = 7'h23;
      6:    w[6:0] = 7'h63;
      7:    w[6:0] = 7'h37;
      8:    w[6:0] = 7'h17;
      9:    w[6:0] = 7'h6f;
      10:   begin w[6:0] = 7'h67; if ($urandom_range(0, 1) == 0) w[14:12] = 3'd0; end
      default: ;
    endcase
    if (k <= 3) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  initial begin
    RST_N = 1'b0;
    in_rst = 1'b1;
    repeat (2) @(negedge CLK);
    check_all();
    RST_N  = 1'b1;
    in_rst = 1'b0;
    cycle_body(1'b1, 1'b0, 1'b0);

    // streaming: ADD, SUB, SRAI
    push(32'h002081B3); push(32'h402081B3); push(32'h4020D193);
    repeat (5) tick(1'b1, 1'b1, 1'b0);

    // backpressure: three offered, two taken, then release
    push(32'h00A00093); push(32'h00112023); push(32'h0000A103);
    repeat (4) tick(1'b0, 1'b1, 1'b0);
    repeat (5) tick(1'b1, 1'b1, 1'b0);

    // illegal encodings, MUL, control transfer, U-types
    push(32'h00000073); push(32'h4020F1B3); push(32'h0020A463); push(32'h023100B3);
    push(32'h00208463); push(32'h008000EF); push(32'h000080E7);
    push(32'h123450B7); push(32'h00001097);
    repeat (12) tick(1'b1, 1'b1, 1'b0);

    // flush with both slots full and a simultaneous input
    push(32'h00308133); push(32'h40308133);
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    push(32'h0041C1B3);
    tick(1'b0, 1'b1, 1'b1);
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    repeat (2) tick(1'b1, 1'b1, 1'b0);

    // reset in the middle of a backed-up stream
    push(32'h00500293); push(32'h00629313); push(32'h0062D393); push(32'h4062D413);
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    do_reset();
    repeat (6) tick(1'b1, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (src.size() < 3) push(rand_ir());
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    check_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
